mac_array_acc: RTL
==================

Name: mac_array_acc

Overview:
- Parametrised multiply-accumulate lane array for the LeNet convolution and FC engines; successor to the fixed 120-lane MAC.
- Each lane computes signed img x ker and adds either an externally supplied partial sum or an internal per-lane accumulator.
- Adds per-lane valid tracking, in-array accumulation with clear/last tagging, global stall, and a sticky overflow flag.
- Sits between the feature-map/weight buffers and the partial-sum/output buffers.

Parameters:
- NUM_MAC, 120: number of MAC lanes.
- LANES_PER_KER, 8: lanes sharing one kernel word; lane i uses kernel i/LANES_PER_KER. NUM_MAC must be a multiple of this.
- DATA_W, 16: signed img and kernel width.
- PART_W, 28: signed external partial-sum width.
- RES_W, 33: signed result and accumulator width; must be >= 2*DATA_W+1 and > PART_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_vld  in  1  input beat valid
- lane_en  in  NUM_MAC  per-lane enable, sampled with in_vld
- acc_mode  in  1  0 = add external partial; 1 = internal accumulate
- acc_clr  in  1  internal mode: first beat of a sum; accumulator is loaded rather than added
- acc_last  in  1  internal mode: last beat of a sum; result emitted
- stall  in  1  freezes the entire pipeline
- img  in  NUM_MAC*DATA_W  lane i at [i*DATA_W +: DATA_W]
- ker  in  (NUM_MAC/LANES_PER_KER)*DATA_W  shared kernel words
- partial_in  in  NUM_MAC*PART_W  external partials, sampled on the partial_prepare cycle
- partial_prepare  out  1  partial_in is consumed this cycle
- result  out  NUM_MAC*RES_W  lane results
- result_vld  out  1  result valid this cycle
- result_lane_en  out  NUM_MAC  lane_en of the beat being output
- ovf  out  1  sticky accumulator overflow

Behaviour:
- Reset (rst=0, asynchronous): all pipeline registers, accumulators, result, result_vld, partial_prepare, result_lane_en and ovf clear to 0.
- Pipeline has 3 stages:
  - S1 registers img, ker, lane_en and the tags (mode, clr, last).
  - S2 registers the signed DATA_W x DATA_W product (2*DATA_W bits).
  - S3 registers the sum.
- A beat accepted at edge t (in_vld=1, stall=0) produces partial_prepare during cycle t+2 if mode=0, and result_vld during cycle t+3.
- Mode is carried with the beat, so mode changes between beats are legal with no bubble.
- External mode (0):
  - S3 = sext(product) + sext(partial_in lane).
  - result_vld=1 on every beat.
- Internal mode (1):
  - If clr is set, acc = sext(product); otherwise acc = acc + sext(product).
  - partial_in is ignored and partial_prepare stays 0.
  - result = acc.
  - result_vld=1 only for beats tagged last. clr and last on the same beat is a single-term sum.
- Disabled lane (lane_en bit 0 for the beat):
  - Its accumulator holds.
  - Its result slice is 0 for that output cycle.
  - Other lanes are unaffected.
- Arithmetic is two's complement and wraps at RES_W. ovf sets when any enabled lane's S3 add overflows RES_W signed. ovf clears only on reset or on an accepted beat with mode=1 and clr=1.
- stall=1:
  - All stage registers, accumulators, result and result_lane_en hold.
  - result_vld and partial_prepare are forced to 0, and partial_in is not sampled.
  - The held beat re-presents its strobe the first cycle stall=0.
  - in_vld during stall is ignored and not accepted.
- in_vld=0 inserts a bubble: no strobes and no accumulator change.
- Back-to-back beats give one result per cycle.
- Reset mid-sum discards the accumulators. The next internal sum must start with clr.
- Internal beat without clr following reset: adds to 0.

Test Plan:
- External mode: img lane0=3, ker0=-4, partial lane0=100, all lanes enabled, one beat → partial_prepare at t+2, result lane0=88 with result_vld at t+3, asserted for exactly 1 cycle.
- Internal mode, 4 beats lane5 img=2 with ker0=5,6,7,8, clr on beat 1, last on beat 4 → single result_vld, lane5=52, partial_prepare never high.
- Kernel sharing: ker words k0=1, k1=2, all img=10 → lanes 0-7 give 10, lanes 8-15 give 20 (external partial=0).
- Stall 2 cycles while a beat is in S2 → result_vld delayed exactly 2 cycles, value unchanged; in_vld during stall has no effect.
- Overflow: internal accumulation of (-32768 x -32768) repeated 4 beats → wrapped value equals 2^32 mod 2^33 signed, ovf=1; next clr beat clears ovf.
- Async reset asserted mid internal sum, released, then a beat without clr with img=1, ker=1 and last → result 1, all outputs 0 while rst=0.

Source files
------------

// File: rtl/mac_array_acc.sv
// mac_array_acc
//   Parametrised signed multiply-accumulate lane array used by the LeNet
//   convolution and FC engines. Each lane computes img x ker. The product
//   is then added either to an external partial sum or to a per-lane
//   internal accumulator. The lane array is a three-stage pipeline with a
//   global stall.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   in_vld          input beat valid
//   lane_en         per-lane enable, captured with the beat
//   acc_mode        0 = add external partial, 1 = internal accumulate
//   acc_clr         internal mode: load accumulator instead of adding
//   acc_last        internal mode: emit result for this beat
//   stall           freeze the whole pipeline
//   img             per-lane image words, lane i at [i*DATA_W +: DATA_W]
//   ker             shared kernel words, lane i uses word i/LANES_PER_KER
//   partial_in      per-lane external partials, sampled while partial_prepare=1
//   partial_prepare partial_in is consumed this cycle
//   result          per-lane results
//   result_vld      result valid this cycle
//   result_lane_en  lane_en of the beat currently on result
//   ovf             sticky signed overflow of any enabled lane's final add
module mac_array_acc #(
  parameter int NUM_MAC       = 120,
  parameter int LANES_PER_KER = 8,
  parameter int DATA_W        = 16,
  parameter int PART_W        = 28,
  parameter int RES_W         = 33
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_vld,
  input  logic [NUM_MAC-1:0]                    lane_en,
  input  logic                                  acc_mode,
  input  logic                                  acc_clr,
  input  logic                                  acc_last,
  input  logic                                  stall,
  input  logic [NUM_MAC*DATA_W-1:0]             img,
  input  logic [(NUM_MAC/LANES_PER_KER)*DATA_W-1:0] ker,
  input  logic [NUM_MAC*PART_W-1:0]             partial_in,
  output logic                                  partial_prepare,
  output logic [NUM_MAC*RES_W-1:0]              result,
  output logic                                  result_vld,
  output logic [NUM_MAC-1:0]                    result_lane_en,
  output logic                                  ovf
);

  localparam int NUM_KER = NUM_MAC / LANES_PER_KER;
  localparam int PROD_W  = 2 * DATA_W;

  if (RES_W < PROD_W + 1 || RES_W <= PART_W || NUM_MAC % LANES_PER_KER != 0) begin : g_param_check
    $error("mac_array_acc: illegal parameter combination");
  end

  // Stage 1: operands and beat tags
  logic                     s1_vld;
  logic                     s1_mode;
  logic                     s1_clr;
  logic                     s1_last;
  logic [NUM_MAC-1:0]       s1_en;
  logic signed [DATA_W-1:0] s1_img [NUM_MAC];
  logic signed [DATA_W-1:0] s1_ker [NUM_KER];

  // Stage 2: products and beat tags
  logic                     s2_vld;
  logic                     s2_mode;
  logic                     s2_clr;
  logic                     s2_last;
  logic [NUM_MAC-1:0]       s2_en;
  logic signed [PROD_W-1:0] s2_prod [NUM_MAC];

  // Stage 3: registered sums and output tags
  logic                     s3_vld;
  logic                     s3_emit;
  logic signed [RES_W-1:0]  res_q [NUM_MAC];
  logic [NUM_MAC-1:0]       res_en_q;
  logic                     ovf_q;

  // Per-lane accumulators (internal mode)
  logic signed [RES_W-1:0]  acc [NUM_MAC];

  // Stage-3 adder inputs and outputs
  logic signed [RES_W-1:0]  prod_x   [NUM_MAC];
  logic signed [RES_W-1:0]  addend_c [NUM_MAC];
  logic signed [RES_W-1:0]  sum_c    [NUM_MAC];
  logic [NUM_MAC-1:0]       add_ovf_c;

  // One adder per lane serves both modes. The addend is the external
  // partial, the accumulator, or zero when a new internal sum starts.
  // A zero addend can never overflow, so clr beats never set ovf.
  always_comb begin
    add_ovf_c = '0;
    for (int unsigned i = 0; i < NUM_MAC; i++) begin
      prod_x[i] = RES_W'(s2_prod[i]);
      if (s2_mode) begin
        addend_c[i] = s2_clr ? '0 : acc[i];
      end else begin
        addend_c[i] = RES_W'($signed(partial_in[i*PART_W +: PART_W]));
      end
      sum_c[i]     = addend_c[i] + prod_x[i];
      add_ovf_c[i] = (addend_c[i][RES_W-1] == prod_x[i][RES_W-1]) &&
                     (sum_c[i][RES_W-1] != addend_c[i][RES_W-1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld   <= 1'b0;
      s1_mode  <= 1'b0;
      s1_clr   <= 1'b0;
      s1_last  <= 1'b0;
      s1_en    <= '0;
      s2_vld   <= 1'b0;
      s2_mode  <= 1'b0;
      s2_clr   <= 1'b0;
      s2_last  <= 1'b0;
      s2_en    <= '0;
      s3_vld   <= 1'b0;
      s3_emit  <= 1'b0;
      res_en_q <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_MAC; i++) begin
        s1_img[i]  <= '0;
        s2_prod[i] <= '0;
        res_q[i]   <= '0;
        acc[i]     <= '0;
      end
      for (int unsigned k = 0; k < NUM_KER; k++) begin
        s1_ker[k] <= '0;
      end
    end else if (!stall) begin
      // Stage 1
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_mode <= acc_mode;
        s1_clr  <= acc_clr;
        s1_last <= acc_last;
        s1_en   <= lane_en;
        for (int unsigned i = 0; i < NUM_MAC; i++) begin
          s1_img[i] <= img[i*DATA_W +: DATA_W];
        end
        for (int unsigned k = 0; k < NUM_KER; k++) begin
          s1_ker[k] <= ker[k*DATA_W +: DATA_W];
        end
      end

      // Stage 2
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_mode <= s1_mode;
        s2_clr  <= s1_clr;
        s2_last <= s1_last;
        s2_en   <= s1_en;
        for (int unsigned i = 0; i < NUM_MAC; i++) begin
          s2_prod[i] <= s1_img[i] * s1_ker[i / LANES_PER_KER];
        end
      end

      // Stage 3: bubbles leave result and accumulators untouched
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_emit  <= !s2_mode || s2_last;
        res_en_q <= s2_en;
        for (int unsigned i = 0; i < NUM_MAC; i++) begin
          if (s2_en[i]) begin
            res_q[i] <= sum_c[i];
            if (s2_mode) begin
              acc[i] <= sum_c[i];
            end
          end else begin
            res_q[i] <= '0;
          end
        end
      end

      // A set from an older beat in S3 takes priority over a clear from
      // the beat being accepted on the same edge, so that no overflow is lost.
      if (s2_vld && |(add_ovf_c & s2_en)) begin
        ovf_q <= 1'b1;
      end else if (in_vld && acc_mode && acc_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Strobes are gated by stall, so a frozen beat re-presents its strobe
  // on the first cycle after the stall is released.
  assign partial_prepare = s2_vld && !s2_mode && !stall;
  assign result_vld      = s3_vld && s3_emit && !stall;
  assign result_lane_en  = res_en_q;
  assign ovf             = ovf_q;

  for (genvar g = 0; g < NUM_MAC; g++) begin : g_result
    assign result[g*RES_W +: RES_W] = res_q[g];
  end

endmodule
